// File: rtl/riscv_alu_q_if_if.sv
// ---------------------------------------------------------------------------
// riscv_alu_q_if_if
//   AHB-lite slave-side bundle for the queued ALU accelerator.
//   master modport: drives the request (address/control/write data) and
//                   receives HREADY/HRESP/HRDATA.
//   slave modport : the mirror image, used by riscv_alu_q_if.
//   Signals:
//     sl_HSEL, sl_HREADY, sl_HTRANS[1:0], sl_HBURST[2:0], sl_HSIZE[2:0],
//     sl_HADDR[31:0], sl_HWRITE, sl_HWDATA[31:0]          (master -> slave)
//     out_sl_HREADY, out_sl_HRESP[1:0], out_sl_HRDATA[31:0] (slave -> master)
// ---------------------------------------------------------------------------
interface riscv_alu_q_if_if;
    logic        sl_HSEL;
    logic        sl_HREADY;
    logic [1:0]  sl_HTRANS;
    logic [2:0]  sl_HBURST;
    logic [2:0]  sl_HSIZE;
    logic [31:0] sl_HADDR;
    logic        sl_HWRITE;
    logic [31:0] sl_HWDATA;
    logic        out_sl_HREADY;
    logic [1:0]  out_sl_HRESP;
    logic [31:0] out_sl_HRDATA;

    modport master (
        output sl_HSEL, sl_HREADY, sl_HTRANS, sl_HBURST, sl_HSIZE,
               sl_HADDR, sl_HWRITE, sl_HWDATA,
        input  out_sl_HREADY, out_sl_HRESP, out_sl_HRDATA
    );

    modport slave (
        input  sl_HSEL, sl_HREADY, sl_HTRANS, sl_HBURST, sl_HSIZE,
               sl_HADDR, sl_HWRITE, sl_HWDATA,
        output out_sl_HREADY, out_sl_HRESP, out_sl_HRDATA
    );
endinterface

// File: rtl/riscv_alu_q_if.sv
// ---------------------------------------------------------------------------
// riscv_alu_q_if
//   Queued AHB-lite ALU accelerator. Operand staging registers A/B feed a
//   command FIFO; commands issue into a PIPE_STAGES-deep ALU pipeline whose
//   results land, in issue order, in a result FIFO read through RESULT.
//   Zero-wait-state, always-OKAY slave.
// Ports:
//   HCLK    : clock, rising edge
//   HRESETn : asynchronous active-low reset
//   bus     : AHB-lite slave bundle (riscv_alu_q_if_if.slave)
//   o_irq   : registered irq_en & result FIFO non-empty
// Register map (HADDR[7:2]):
//   0x00 OP(W) 0x04 A(RW) 0x08 B(RW) 0x0C RESULT(RO) 0x10 STATUS(RO) 0x14 CTRL(RW)
// Op codes (OP write data [3:0]):
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU;
//   anything else yields 0.
// ---------------------------------------------------------------------------
module riscv_alu_q_if #(
    parameter int CMD_DEPTH   = 4,
    parameter int RES_DEPTH   = 4,
    parameter int PIPE_STAGES = 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    riscv_alu_q_if_if.slave  bus,
    output logic             o_irq
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int CCW = CAW + 1;
    localparam int RCW = RAW + 1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [5:0] R_OP = 6'd0, R_A = 6'd1, R_B = 6'd2;
    localparam logic [5:0] R_RES = 6'd3, R_STAT = 6'd4, R_CTRL = 6'd5;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    function automatic logic [31:0] alu_f(input cmd_t c);
        logic [31:0] r;
        case (c.op)
            ALU_ADD:  r = c.a + c.b;
            ALU_SUB:  r = c.a - c.b;
            ALU_AND:  r = c.a & c.b;
            ALU_OR:   r = c.a | c.b;
            ALU_XOR:  r = c.a ^ c.b;
            ALU_SLL:  r = c.a << c.b[4:0];
            ALU_SRL:  r = c.a >> c.b[4:0];
            ALU_SRA:  r = $signed(c.a) >>> c.b[4:0];
            ALU_SLT:  r = {31'd0, $signed(c.a) < $signed(c.b)};
            ALU_SLTU: r = {31'd0, c.a < c.b};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // ---------------- address phase capture ----------------
    logic       ap_vld_q, ap_wr_q;
    logic [5:0] ap_reg_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_vld_q <= 1'b0;
            ap_wr_q  <= 1'b0;
            ap_reg_q <= '0;
        end else if (bus.sl_HREADY) begin
            ap_vld_q <= bus.sl_HSEL & bus.sl_HTRANS[1];
            ap_wr_q  <= bus.sl_HWRITE;
            ap_reg_q <= bus.sl_HADDR[7:2];
        end
    end

    logic wr_op, wr_a, wr_b, wr_ctrl, rd_res, rd;
    assign rd      = ap_vld_q & ~ap_wr_q;
    assign wr_op   = ap_vld_q & ap_wr_q & (ap_reg_q == R_OP);
    assign wr_a    = ap_vld_q & ap_wr_q & (ap_reg_q == R_A);
    assign wr_b    = ap_vld_q & ap_wr_q & (ap_reg_q == R_B);
    assign wr_ctrl = ap_vld_q & ap_wr_q & (ap_reg_q == R_CTRL);
    assign rd_res  = rd & (ap_reg_q == R_RES);

    logic flush, clr_sticky;
    assign flush      = wr_ctrl & bus.sl_HWDATA[2];
    assign clr_sticky = wr_ctrl & bus.sl_HWDATA[1];

    // ---------------- staging / control ----------------
    logic [31:0] a_q, b_q;
    logic        irq_en_q, irq_en_d, ovf_q, udf_q, irq_q;

    assign irq_en_d = wr_ctrl ? bus.sl_HWDATA[0] : irq_en_q;

    // ---------------- command FIFO ----------------
    cmd_t           cmd_mem_q [CMD_DEPTH];
    logic [CAW-1:0] cmd_wp_q, cmd_rp_q;
    logic [CCW-1:0] cmd_cnt_q;
    logic           cmd_full, cmd_empty, cmd_push, issue, ovf_set;

    // ---------------- pipeline ----------------
    logic [PIPE_STAGES:0] vld_pipe_q;
    cmd_t                 iss_q;
    logic [3:0]           in_flight;
    logic [31:0]          stg_d [PIPE_STAGES+1];

    // ---------------- result FIFO ----------------
    logic [31:0]    res_mem_q [RES_DEPTH];
    logic [RAW-1:0] res_wp_q, res_rp_q;
    logic [RCW-1:0] res_cnt_q, res_cnt_d;
    logic           res_full, res_empty, res_push, res_pop, udf_set;

    assign cmd_full  = (cmd_cnt_q == CCW'(CMD_DEPTH));
    assign cmd_empty = (cmd_cnt_q == '0);
    assign res_full  = (res_cnt_q == RCW'(RES_DEPTH));
    assign res_empty = (res_cnt_q == '0);

    always_comb begin
        in_flight = '0;
        for (int k = 0; k <= PIPE_STAGES; k++)
            in_flight = in_flight + 4'(vld_pipe_q[k]);
    end

    // Issue only when a result slot is reserved for every op already in
    // flight plus this one, so the pipeline never has to stall.
    assign issue    = ~cmd_empty & ~flush &
                      ((32'(res_cnt_q) + 32'(in_flight)) < 32'(RES_DEPTH));
    // A full FIFO still accepts if its head leaves on the same edge.
    assign cmd_push = wr_op & (~cmd_full | issue);
    assign ovf_set  = wr_op & cmd_full & ~issue;

    assign res_push = vld_pipe_q[PIPE_STAGES];
    assign res_pop  = rd_res & ~res_empty;
    assign udf_set  = rd_res & res_empty;

    assign res_cnt_d = flush ? '0 : res_cnt_q + RCW'(res_push) - RCW'(res_pop);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_q      <= '0;
            b_q      <= '0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_a) a_q <= bus.sl_HWDATA;
            if (wr_b) b_q <= bus.sl_HWDATA;
            irq_en_q <= irq_en_d;
            ovf_q    <= (ovf_q & ~clr_sticky) | ovf_set;
            udf_q    <= (udf_q & ~clr_sticky) | udf_set;
            irq_q    <= irq_en_d & (res_cnt_d != '0);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= '0;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
        end else if (flush) begin
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem_q[cmd_wp_q] <= '{op: bus.sl_HWDATA[3:0], a: a_q, b: b_q};
                cmd_wp_q            <= cmd_wp_q + 1'b1;
            end
            if (issue) cmd_rp_q <= cmd_rp_q + 1'b1;
            cmd_cnt_q <= cmd_cnt_q + CCW'(cmd_push) - CCW'(issue);
        end
    end

    // Slot 0 is the issue register; result stages follow it.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vld_pipe_q <= '0;
            iss_q      <= '0;
        end else begin
            vld_pipe_q    <= flush ? '0 : {vld_pipe_q[PIPE_STAGES:0] << 1} | (PIPE_STAGES+1)'(issue);
            if (issue) iss_q <= cmd_mem_q[cmd_rp_q];
        end
    end

    assign stg_d[0] = alu_f(iss_q);

    for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stg
        logic [31:0] r_q;
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) r_q <= '0;
            else          r_q <= stg_d[k-1];
        end
        assign stg_d[k] = r_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < RES_DEPTH; i++) res_mem_q[i] <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            if (flush) begin
                res_wp_q <= '0;
                res_rp_q <= '0;
            end else begin
                if (res_push) begin
                    res_mem_q[res_wp_q] <= stg_d[PIPE_STAGES];
                    res_wp_q            <= res_wp_q + 1'b1;
                end
                if (res_pop) res_rp_q <= res_rp_q + 1'b1;
            end
            res_cnt_q <= res_cnt_d;
        end
    end

    // ---------------- read data ----------------
    logic [31:0] cc32, rc32, status;
    assign cc32   = 32'(cmd_cnt_q);
    assign rc32   = 32'(res_cnt_q);
    assign status = {12'd0, rc32[3:0], 4'd0, cc32[3:0], 1'b0, udf_q, ovf_q,
                     (vld_pipe_q != '0), res_empty, res_full, cmd_empty, cmd_full};

    always_comb begin
        bus.out_sl_HRDATA = '0;
        if (rd) begin
            case (ap_reg_q)
                R_A:     bus.out_sl_HRDATA = a_q;
                R_B:     bus.out_sl_HRDATA = b_q;
                R_RES:   bus.out_sl_HRDATA = res_empty ? 32'd0 : res_mem_q[res_rp_q];
                R_STAT:  bus.out_sl_HRDATA = status;
                R_CTRL:  bus.out_sl_HRDATA = {31'd0, irq_en_q};
                default: bus.out_sl_HRDATA = '0;
            endcase
        end
    end

    assign bus.out_sl_HREADY = 1'b1;
    assign bus.out_sl_HRESP  = 2'b00;
    assign o_irq             = irq_q;

    logic unused_ok;
    assign unused_ok = ^{bus.sl_HBURST, bus.sl_HSIZE, bus.sl_HADDR[31:8],
                         bus.sl_HADDR[1:0], bus.sl_HTRANS[0], cc32[31:4], rc32[31:4]};
endmodule

// File: tb/tb_riscv_alu_q_if.sv
module tb_riscv_alu_q_if;
    localparam int PIPE = 1;

    localparam logic [3:0] ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8, ALU_SLTU = 4'd9;

    localparam logic [31:0] A_OP = 32'h00, A_A = 32'h04, A_B = 32'h08;
    localparam logic [31:0] A_RES = 32'h0C, A_ST = 32'h10, A_CTRL = 32'h14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    riscv_alu_q_if_if bus();
    assign bus.sl_HREADY = bus.out_sl_HREADY;

    riscv_alu_q_if #(.CMD_DEPTH(4), .RES_DEPTH(4), .PIPE_STAGES(PIPE)) dut (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus), .o_irq(irq)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        @(negedge clk);
        bus.sl_HSEL = 1'b1; bus.sl_HTRANS = 2'b10; bus.sl_HADDR = addr; bus.sl_HWRITE = 1'b1;
        @(negedge clk);
        bus.sl_HSEL = 1'b0; bus.sl_HTRANS = 2'b00; bus.sl_HWDATA = d;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        @(negedge clk);
        bus.sl_HSEL = 1'b1; bus.sl_HTRANS = 2'b10; bus.sl_HADDR = addr; bus.sl_HWRITE = 1'b0;
        @(negedge clk);
        bus.sl_HSEL = 1'b0; bus.sl_HTRANS = 2'b00;
        d = bus.out_sl_HRDATA;
    endtask

    task automatic op3(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        wr(A_A, a);
        wr(A_B, b);
        wr(A_OP, {28'd0, op});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int k;

        vecs[0]  = '{ALU_ADD,  32'h0000_0008, 32'h0000_0008, 32'h0000_0010};
        vecs[1]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[2]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002};
        vecs[3]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[4]  = '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[5]  = '{ALU_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
        vecs[6]  = '{ALU_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
        vecs[7]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        vecs[8]  = '{ALU_SLL,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006};
        vecs[9]  = '{ALU_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[10] = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[11] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[12] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[13] = '{ALU_SLT,  32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000};
        vecs[14] = '{4'hC,     32'h1234_5678, 32'h0000_0001, 32'h0000_0000};

        bus.sl_HSEL = 1'b0; bus.sl_HTRANS = 2'b00; bus.sl_HBURST = 3'b000;
        bus.sl_HSIZE = 3'b010; bus.sl_HADDR = '0; bus.sl_HWRITE = 1'b0; bus.sl_HWDATA = '0;
        idle(3);
        rst_n = 1'b1;

        // 1: reset state and empty read
        rd(A_ST, d);  chk("reset_status", d, 32'h0000_000A);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        rd(A_RES, d); chk("empty_result", d, 32'h0);
        rd(A_ST, d);  chk("udf_status", d, 32'h0000_004A);
        wr(A_CTRL, 32'h2);
        rd(A_ST, d);  chk("udf_cleared", d, 32'h0000_000A);

        // 2: basic ADD
        op3(ALU_ADD, 32'd8, 32'd8);
        idle(PIPE + 4);
        rd(A_RES, d); chk("add_8_8", d, 32'h10);
        rd(A_ST, d);  chk("status_after_add", d, 32'h0000_000A);

        // Table of ALU vectors
        for (int i = 0; i < 15; i++) begin
            op3(vecs[i].op, vecs[i].a, vecs[i].b);
            idle(PIPE + 4);
            rd(A_RES, d);
            chk($sformatf("vec%0d", i), d, vecs[i].exp);
        end

        // 3: back-to-back ops, in-order results
        op3(ALU_ADD,  32'd1, 32'd2);
        op3(ALU_SUB,  32'd5, 32'd3);
        op3(ALU_SLT,  32'hFFFF_FFFF, 32'd1);
        op3(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        idle(PIPE + 4);
        rd(A_RES, d); chk("b2b_0", d, 32'd3);
        rd(A_RES, d); chk("b2b_1", d, 32'd2);
        rd(A_RES, d); chk("b2b_2", d, 32'd1);
        rd(A_RES, d); chk("b2b_3", d, 32'd0);

        // Simultaneous result push and RESULT pop
        op3(ALU_ADD, 32'd1, 32'd1);
        idle(PIPE + 4);
        op3(ALU_ADD, 32'd4, 32'd0);
        idle(PIPE);
        rd(A_RES, d); chk("pushpop_old", d, 32'd2);
        rd(A_ST, d);  chk("pushpop_status", d, 32'h0001_0002);
        rd(A_RES, d); chk("pushpop_new", d, 32'd4);

        // 4: overflow with 9 ops and no reads
        wr(A_B, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            wr(A_A, i);
            wr(A_OP, {28'd0, ALU_ADD});
        end
        idle(PIPE + 4);
        rd(A_ST, d); chk("ovf_status", d, 32'h0004_0425);
        // RESULT read pipelined with an OP write that lands while the FIFO
        // is full but its head issues on the same edge: must be accepted.
        @(negedge clk);
        bus.sl_HSEL = 1'b1; bus.sl_HTRANS = 2'b10; bus.sl_HADDR = A_RES; bus.sl_HWRITE = 1'b0;
        @(negedge clk);
        d = bus.out_sl_HRDATA;
        bus.sl_HADDR = A_OP; bus.sl_HWRITE = 1'b1;
        @(negedge clk);
        bus.sl_HSEL = 1'b0; bus.sl_HTRANS = 2'b00; bus.sl_HWDATA = {28'd0, ALU_ADD};
        chk("drain_1", d, 32'd1);
        for (int i = 2; i <= 9; i++) begin
            idle(PIPE + 4);
            rd(A_RES, d);
            chk($sformatf("drain_%0d", i), d, i);
        end
        rd(A_ST, d); chk("ovf_kept", d, 32'h0000_002A);
        wr(A_CTRL, 32'h2);
        rd(A_ST, d); chk("ovf_cleared", d, 32'h0000_000A);

        // 5: interrupt
        wr(A_CTRL, 32'h1);
        op3(ALU_ADD, 32'd2, 32'd3);
        k = 0;
        while (irq !== 1'b1 && k < PIPE + 4) begin
            @(posedge clk); #1;
            k++;
        end
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd(A_RES, d); chk("irq_result", d, 32'd5);
        @(posedge clk); #1;
        chk("irq_clear", {31'd0, irq}, 32'd0);

        // 6a: flush with ops in flight; staging and irq_en survive
        op3(ALU_ADD, 32'd1, 32'd1);
        op3(ALU_ADD, 32'd2, 32'd2);
        op3(ALU_ADD, 32'h55, 32'd3);
        wr(A_CTRL, 32'h5);
        idle(PIPE + 4);
        rd(A_ST, d);   chk("flush_status", d, 32'h0000_000A);
        chk("flush_irq", {31'd0, irq}, 32'd0);
        rd(A_A, d);    chk("flush_keep_a", d, 32'h55);
        rd(A_CTRL, d); chk("flush_keep_irqen", d, 32'h1);
        rd(A_RES, d);  chk("flush_result", d, 32'h0);
        rd(A_ST, d);   chk("flush_udf", d, 32'h0000_004A);

        // 6b: reset mid-operation
        op3(ALU_ADD, 32'd7, 32'd1);
        op3(ALU_ADD, 32'd9, 32'd1);
        op3(ALU_SUB, 32'd9, 32'd1);
        do_reset();
        rd(A_ST, d);   chk("rst_status", d, 32'h0000_000A);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(A_A, d);    chk("rst_a", d, 32'h0);
        rd(A_CTRL, d); chk("rst_ctrl", d, 32'h0);
        idle(PIPE + 4);
        rd(A_RES, d);  chk("rst_result", d, 32'h0);
        rd(A_ST, d);   chk("rst_udf", d, 32'h0000_004A);

        // Unmapped register
        wr(32'h20, 32'hDEAD_BEEF);
        rd(32'h20, d); chk("unmapped", d, 32'h0);
        rd(A_OP, d);   chk("op_reads_0", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
